// File: rtl/ex_mem_if.sv
// EX-to-MEM bundle: EX-side write-back fields in, registered MEM-side
// fields and the saved multi-cycle context out.
interface ex_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
);
    logic                ex_valid;
    logic [ADDR_W-1:0]   ex_wd;
    logic                ex_wreg;
    logic [DATA_W-1:0]   ex_wdata;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic                ex_whilo;
    logic [2*DATA_W-1:0] hilo_i;
    logic [CNT_W-1:0]    cnt_i;

    logic                mem_valid;
    logic [ADDR_W-1:0]   mem_wd;
    logic                mem_wreg;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic                mem_whilo;
    logic [2*DATA_W-1:0] hilo_o;
    logic [CNT_W-1:0]    cnt_o;
    logic                mc_busy;

    modport master (
        output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_i, cnt_i,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
               hilo_o, cnt_o, mc_busy
    );

    modport slave (
        input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_i, cnt_i,
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
               hilo_o, cnt_o, mc_busy
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flush, bubble insertion, multi-cycle
// context save across EX stalls and a saturating bubble-cycle counter.
module ex_mem_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 6,
    parameter int EX_IDX  = 3,
    parameter int MEM_IDX = 4,
    parameter int SCNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    ex_mem_if.slave            bus,
    output logic [SCNT_W-1:0]  stall_cycles
);
    typedef enum logic [1:0] {
        OP_HOLD    = 2'd0,
        OP_ADVANCE = 2'd1,
        OP_BUBBLE  = 2'd2,
        OP_FLUSH   = 2'd3
    } op_e;

    op_e                 op_s;
    logic                mem_valid_r;
    logic [ADDR_W-1:0]   mem_wd_r;
    logic                mem_wreg_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [DATA_W-1:0]   mem_hi_r;
    logic [DATA_W-1:0]   mem_lo_r;
    logic                mem_whilo_r;
    logic [2*DATA_W-1:0] hilo_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [SCNT_W-1:0]   stall_cycles_r;

    // Edge action decode; an EX-running/MEM-stalled vector falls through to advance.
    always_comb begin
        op_s = OP_HOLD;
        if (flush) begin
            op_s = OP_FLUSH;
        end else if (stall[EX_IDX] && !stall[MEM_IDX]) begin
            op_s = OP_BUBBLE;
        end else if (!stall[EX_IDX]) begin
            op_s = OP_ADVANCE;
        end else begin
            op_s = OP_HOLD;
        end
    end

    // Pipeline, context and bubble-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_r    <= 1'b0;
            mem_wd_r       <= '0;
            mem_wreg_r     <= 1'b0;
            mem_wdata_r    <= '0;
            mem_hi_r       <= '0;
            mem_lo_r       <= '0;
            mem_whilo_r    <= 1'b0;
            hilo_r         <= '0;
            cnt_r          <= '0;
            stall_cycles_r <= '0;
        end else begin
            case (op_s)
                OP_FLUSH, OP_BUBBLE: begin
                    mem_valid_r <= 1'b0;
                    mem_wd_r    <= '0;
                    mem_wreg_r  <= 1'b0;
                    mem_wdata_r <= '0;
                    mem_hi_r    <= '0;
                    mem_lo_r    <= '0;
                    mem_whilo_r <= 1'b0;
                    if (op_s == OP_BUBBLE) begin
                        hilo_r <= bus.hilo_i;
                        cnt_r  <= bus.cnt_i;
                        if (stall_cycles_r != {SCNT_W{1'b1}}) begin
                            stall_cycles_r <= stall_cycles_r + SCNT_W'(1);
                        end else begin
                            stall_cycles_r <= stall_cycles_r;
                        end
                    end else begin
                        hilo_r         <= '0;
                        cnt_r          <= '0;
                        stall_cycles_r <= '0;
                    end
                end
                OP_ADVANCE: begin
                    // Data is copied even for a non-instruction; only enables are gated.
                    mem_valid_r    <= bus.ex_valid;
                    mem_wd_r       <= bus.ex_wd;
                    mem_wreg_r     <= bus.ex_wreg & bus.ex_valid;
                    mem_wdata_r    <= bus.ex_wdata;
                    mem_hi_r       <= bus.ex_hi;
                    mem_lo_r       <= bus.ex_lo;
                    mem_whilo_r    <= bus.ex_whilo & bus.ex_valid;
                    hilo_r         <= '0;
                    cnt_r          <= '0;
                    stall_cycles_r <= '0;
                end
                default: begin
                    mem_valid_r    <= mem_valid_r;
                    stall_cycles_r <= stall_cycles_r;
                end
            endcase
        end
    end

    assign bus.mem_valid = mem_valid_r;
    assign bus.mem_wd    = mem_wd_r;
    assign bus.mem_wreg  = mem_wreg_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_hi    = mem_hi_r;
    assign bus.mem_lo    = mem_lo_r;
    assign bus.mem_whilo = mem_whilo_r;
    assign bus.hilo_o    = hilo_r;
    assign bus.cnt_o     = cnt_r;
    assign bus.mc_busy   = (cnt_r != {CNT_W{1'b0}});
    assign stall_cycles  = stall_cycles_r;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized
// traffic against a behavioural next-state model.
module tb_ex_mem_stage;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 2;
    localparam int SW  = 6;
    localparam int SCW = 2;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] wd;
        logic          wreg;
        logic [DW-1:0] wdata;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic          whilo;
        logic [2*DW-1:0] hilo;
        logic [CW-1:0] cnt;
        logic          busy;
        logic [SCW-1:0] scnt;
    } st_t;

    logic clk;
    logic rst;
    logic [SW-1:0] stall;
    logic flush;
    logic [SCW-1:0] stall_cycles;

    ex_mem_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    ex_mem_stage #(
        .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .STALL_W(SW),
        .EX_IDX(3), .MEM_IDX(4), .SCNT_W(SCW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .bus(bus), .stall_cycles(stall_cycles)
    );

    int  vectors = 0;
    int  miscompares = 0;
    st_t exp_s;
    st_t o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic st_t observe();
        st_t r;
        r.valid = bus.mem_valid;  r.wd = bus.mem_wd;       r.wreg = bus.mem_wreg;
        r.wdata = bus.mem_wdata;  r.hi = bus.mem_hi;       r.lo = bus.mem_lo;
        r.whilo = bus.mem_whilo;  r.hilo = bus.hilo_o;     r.cnt = bus.cnt_o;
        r.busy  = bus.mc_busy;    r.scnt = stall_cycles;
        return r;
    endfunction

    // Spec rules: flush beats everything; EX stalled with MEM running is a bubble;
    // both stalled holds; EX running (any MEM bit) advances.
    function automatic st_t model_next(st_t cur);
        st_t n = '0;
        bit ex_st = stall[3];
        bit mem_st = stall[4];
        if (flush) begin
            n = '0;
        end else if (ex_st && mem_st) begin
            n = cur;
        end else if (ex_st) begin
            n.hilo = bus.hilo_i;
            n.cnt  = bus.cnt_i;
            n.scnt = (int'(cur.scnt) + 1 > 3) ? 2'd3 : SCW'(int'(cur.scnt) + 1);
        end else begin
            n.valid = bus.ex_valid;  n.wd = bus.ex_wd;  n.wdata = bus.ex_wdata;
            n.hi = bus.ex_hi;        n.lo = bus.ex_lo;
            n.wreg  = bus.ex_valid ? bus.ex_wreg : 1'b0;
            n.whilo = bus.ex_valid ? bus.ex_whilo : 1'b0;
        end
        n.busy = (n.cnt != 0);
        return n;
    endfunction

    task automatic step();
        st_t n = model_next(exp_s);
        @(posedge clk);
        #1;
        exp_s = n;
    endtask

    task automatic rand_ex();
        bus.ex_valid = 1'($urandom);       bus.ex_wd = AW'($urandom);
        bus.ex_wreg  = 1'($urandom);       bus.ex_wdata = $urandom;
        bus.ex_hi    = $urandom;           bus.ex_lo = $urandom;
        bus.ex_whilo = 1'($urandom);       bus.hilo_i = {$urandom, $urandom};
        bus.cnt_i    = CW'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; stall = 6'b000000;
        rand_ex();
        exp_s = '0;
        repeat (2) @(posedge clk);
        #1;
        o = observe();
        vectors++;
        if (o !== exp_s) begin
            $display("FAIL reset got=%h exp=%h", o, exp_s); miscompares++;
        end
        rst = 1'b1;
    endtask

    task automatic test_reset_midop();
        stall = 6'b000000; flush = 1'b0;
        bus.ex_valid = 1'b1; bus.ex_wd = 5'd5; bus.ex_wreg = 1'b1; bus.ex_wdata = 32'hDEADBEEF;
        step();
        o = observe();
        vectors++;
        if (o.wd !== 5'd5 || o.wdata !== 32'hDEADBEEF || o.valid !== 1'b1 || o !== exp_s) begin
            $display("FAIL midop_advance got=%h exp=%h", o, exp_s); miscompares++;
        end
        #2 rst = 1'b0;
        #1;
        exp_s = '0;
        o = observe();
        vectors++;
        if (o !== exp_s) begin
            $display("FAIL async_reset got=%h exp=%h", o, exp_s); miscompares++;
        end
        #1 rst = 1'b1;
    endtask

    task automatic test_bubble_save();
        flush = 1'b0; stall = 6'b001111;
        bus.hilo_i = 64'h1234_5678_9ABC_DEF0; bus.cnt_i = 2'd1;
        step();
        o = observe();
        vectors++;
        if (o.wreg !== 1'b0 || o.valid !== 1'b0 || o.hilo !== 64'h1234_5678_9ABC_DEF0 ||
            o.cnt !== 2'd1 || o.busy !== 1'b1 || o.scnt !== 2'd1 || o !== exp_s) begin
            $display("FAIL bubble1 got=%h exp=%h", o, exp_s); miscompares++;
        end
        bus.cnt_i = 2'd2;
        step();
        o = observe();
        vectors++;
        if (o.cnt !== 2'd2 || o.scnt !== 2'd2 || o !== exp_s) begin
            $display("FAIL bubble2 got=%h exp=%h", o, exp_s); miscompares++;
        end
    endtask

    task automatic test_release();
        stall = 6'b000000; bus.ex_valid = 1'b1; bus.ex_whilo = 1'b1;
        bus.ex_hi = 32'h0000000A; bus.ex_lo = 32'h0000000B;
        step();
        o = observe();
        vectors++;
        if (o.whilo !== 1'b1 || o.hi !== 32'hA || o.lo !== 32'hB || o.hilo !== 64'd0 ||
            o.cnt !== 2'd0 || o.busy !== 1'b0 || o.scnt !== 2'd0 || o !== exp_s) begin
            $display("FAIL release got=%h exp=%h", o, exp_s); miscompares++;
        end
    endtask

    task automatic test_hold();
        st_t snap;
        stall = 6'b001111; bus.cnt_i = 2'd3; bus.hilo_i = 64'hCAFE_F00D_0BAD_BEEF;
        step();
        snap = exp_s;
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            step();
            o = observe();
            vectors++;
            if (o !== snap || o !== exp_s) begin
                $display("FAIL hold%0d got=%h exp=%h", i, o, snap); miscompares++;
            end
        end
    endtask

    task automatic test_flush_priority();
        flush = 1'b1; stall = 6'b001111; bus.cnt_i = 2'd3; bus.ex_valid = 1'b1;
        bus.ex_wreg = 1'b1; bus.ex_wd = 5'd9;
        step();
        flush = 1'b0;
        o = observe();
        vectors++;
        if (o !== st_t'(0) || o !== exp_s) begin
            $display("FAIL flush_prio got=%h exp=%h", o, exp_s); miscompares++;
        end
    endtask

    task automatic test_saturation_invalid();
        stall = 6'b001111;
        for (int i = 0; i < 5; i++) begin
            rand_ex();
            step();
            o = observe();
            vectors++;
            if (o.scnt !== ((i >= 2) ? 2'd3 : SCW'(i + 1)) || o !== exp_s) begin
                $display("FAIL sat%0d got=%h exp=%h", i, o, exp_s); miscompares++;
            end
        end
        stall = 6'b000000; bus.ex_valid = 1'b0; bus.ex_wreg = 1'b1;
        step();
        o = observe();
        vectors++;
        if (o.wreg !== 1'b0 || o.valid !== 1'b0 || o.scnt !== 2'd0 || o !== exp_s) begin
            $display("FAIL invalid_adv got=%h exp=%h", o, exp_s); miscompares++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_ex();
            flush = ($urandom_range(0, 7) == 0);
            stall = SW'($urandom);
            case ($urandom_range(0, 3))
                0: begin stall[3] = 1'b0; stall[4] = 1'b0; end
                1: begin stall[3] = 1'b1; stall[4] = 1'b0; end
                2: begin stall[3] = 1'b1; stall[4] = 1'b1; end
                default: begin stall[3] = 1'b0; stall[4] = 1'b1; end
            endcase
            step();
            o = observe();
            vectors++;
            if (o !== exp_s) begin
                $display("FAIL random%0d got=%h exp=%h", i, o, exp_s); miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midop();
        test_bubble_save();
        test_release();
        test_hold();
        test_flush_priority();
        test_saturation_invalid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
